rr_mux_reg: RTL and testbench
=============================

// Module: rr_mux_reg
// PURPOSE
//  Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes.
//  Two selection modes: fixed select (sel port) or round-robin across valid channels.
//  The winning beat is captured into a single output register tagged with its source channel.
//  Sits between multiple producers and one consumer (e.g. serialiser, shared bus).
// PARAMETERS
//  N_CH   8   number of input channels (>=2)
//  WIDTH  8   data bits per channel
//  SEL_W  $clog2(N_CH)   localparam, select/channel-index width
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  in_data    in   N_CH*WIDTH   channel i data = in_data[i*WIDTH +: WIDTH]
//  in_valid   in   N_CH         per-channel valid
//  in_ready   out  N_CH         per-channel ready; one-hot or zero
//  mode       in   1            0 = fixed select, 1 = round-robin
//  sel        in   SEL_W        channel index used when mode=0
//  out_data   out  WIDTH        registered output data
//  out_ch     out  SEL_W        source channel of out_data
//  out_valid  out  1            output register holds a beat
//  out_ready  in   1            consumer accepts beat when out_valid && out_ready
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - out_valid=0, out_data=0, out_ch=0, rr_ptr=N_CH-1.
//  - The first round-robin search therefore starts at ch0.
//  Output register states:
//  - EMPTY (out_valid=0): load is enabled.
//  - FULL (out_valid=1): load is enabled only if out_ready=1 in the same cycle (drain+refill).
//  - load_en = !out_valid || out_ready.
//  Grant (combinational, evaluated each cycle):
//  - mode=0:
//    - gnt=sel if sel<N_CH && in_valid[sel]; otherwise no grant.
//    - sel>=N_CH never grants.
//  - mode=1:
//    - gnt = first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo N_CH.
//    - The search wraps N_CH-1 -> 0; no valid channel means no grant.
//  Ready:
//  - in_ready[gnt]=load_en when a grant exists; all other in_ready bits are 0.
//  - No combinational path from in_data to in_ready.
//  Transfer:
//  - Channel i transfers when in_valid[i] && in_ready[i].
//  - Next edge: out_data<=data[i], out_ch<=i, out_valid<=1.
//  - Latency: input handshake cycle -> out_valid on the next cycle (1 clk).
//  - Full throughput: 1 beat/clk while out_ready stays high.
//  Drain with no transfer:
//  - out_valid&&out_ready with no grant -> out_valid<=0.
//  - out_data and out_ch hold their values.
//  Stall:
//  - out_valid && !out_ready -> out_data, out_ch and out_valid hold.
//  - All in_ready bits are 0.
//  rr_ptr:
//  - Updates to gnt only on a transfer, in either mode.
//  - A mode switch continues round-robin fairness from the last served channel.
//  Mode/sel changes:
//  - Take effect on the next grant evaluation.
//  - Never alter a beat already in the output register.
//  Fairness (mode=1): with all channels continuously valid and out_ready=1, service order is 0,1,..,N_CH-1,0,...
//  Reset mid-operation:
//  - The held beat is discarded and out_valid drops immediately (async).
//  - No input handshake completes while rst_n=0.
// TESTING
//  1. Reset: rst_n=0 with in_valid=8'hFF -> out_valid=0, in_ready=0; release, mode=1 -> first out_ch=0.
//  2. Fixed mode: mode=0, sel=3, ch3 data=8'hA5 valid, out_ready=1 -> next cycle out_data=A5, out_ch=3; in_ready=8'b0000_1000.
//  3. Round-robin wrap: mode=1, all valid, out_ready=1 for 10 clk -> out_ch sequence 0..7,0,1.
//  4. Skip idle: mode=1, valid only ch2 and ch6, rr_ptr=2 -> grants 6,2,6,2; channels 3,4,5,7 never granted.
//  5. Back-pressure: out_valid=1, out_ready=0 for 5 clk -> outputs stable, in_ready=0; on out_ready=1 the next beat loads in the same cycle.
//  6. Async reset mid-stream at random phase -> out_valid=0 with no clk edge; post-release order restarts at ch0.

Source files
------------

// File: rtl/rr_mux_reg.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_reg
// Purpose  : N-channel registered multiplexer with valid/ready handshakes.
//            Channel selection is either a fixed index (sel) or round-robin
//            over the valid channels; the winning beat is captured into one
//            output register tagged with its source channel.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_reg #(
    parameter  int N_CH  = 8,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(N_CH - 1);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_fix_vld;
    logic [SEL_W-1:0] w_fix_gnt;
    logic             w_rr_vld;
    logic [SEL_W-1:0] w_rr_gnt;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_gnt;
    logic             w_load_en;
    logic             w_xfer;
    logic [WIDTH-1:0] w_gnt_data;

    // Channel index reached k steps after ptr, wrapping modulo N_CH.
    function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] ptr, input int k);
        int t;
        t = (int'(ptr) + k) % N_CH;
        return SEL_W'(t);
    endfunction

    // Fixed-select grant: sel must name an existing, valid channel.
    always_comb begin
        w_fix_vld = 1'b0;
        w_fix_gnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                w_fix_vld = 1'b1;
                w_fix_gnt = SEL_W'(i);
            end
        end
    end

    // Round-robin grant: scan from rr_ptr+1 onward; iterating the offsets in
    // descending order lets the nearest valid channel be the last writer.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_gnt = '0;
        for (int k = N_CH; k >= 1; k--) begin
            if (in_valid[rr_index(r_rr_ptr, k)]) begin
                w_rr_vld = 1'b1;
                w_rr_gnt = rr_index(r_rr_ptr, k);
            end
        end
    end

    // Mode mux, load enable and transfer qualification. Reset gates the load
    // so no input handshake can complete while rst_n is low.
    always_comb begin
        w_gnt_vld = mode ? w_rr_vld : w_fix_vld;
        w_gnt     = mode ? w_rr_gnt : w_fix_gnt;
        w_load_en = rst_n && (!r_out_valid || out_ready);
        w_xfer    = w_gnt_vld && w_load_en;
    end

    // Data of the granted channel; depends only on the grant, never feeds ready.
    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt == SEL_W'(i)) begin
                w_gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot ready towards the granted producer only.
    for (genvar i = 0; i < N_CH; i++) begin : g_ready
        assign in_ready[i] = w_xfer && (w_gnt == SEL_W'(i));
    end

    // Output register: load on transfer, clear valid on drain, hold on stall.
    // The pointer tracks the last served channel in either mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= c_last_ch;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_ch    <= w_gnt;
            r_rr_ptr    <= w_gnt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_reg
// Purpose  : Self-checking bench for rr_mux_reg against a behavioural model
//            (last-served pointer plus a one-entry output slot).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_reg;

    localparam int N = 8;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0] in_valid;
    logic [N-1:0] in_ready;
    logic         mode;
    logic [2:0]   sel;
    logic [W-1:0] out_data;
    logic [2:0]   out_ch;
    logic         out_valid;
    logic         out_ready;

    int errors;
    int checks;

    // Model state
    bit         m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;

    rr_mux_reg #(.N_CH(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_grant();
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_ready();
        int g;
        bit load;
        g = model_grant();
        load = rst_n && (!m_valid || out_ready);
        if (g >= 0 && load) return 8'(1 << g);
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ch    = 0;
        m_ptr   = N - 1;
    endtask

    // Advance one clock, updating the model with the inputs seen at the edge.
    task automatic tick();
        int g;
        bit load;
        g = model_grant();
        load = rst_n && (!m_valid || out_ready);
        @(posedge clk);
        if (rst_n) begin
            if (g >= 0 && load) begin
                m_valid = 1'b1;
                m_data  = in_data[g*W +: W];
                m_ch    = g;
                m_ptr   = g;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 8'hFF;
        in_data = {$urandom, $urandom};
        mode = 1'b1;
        sel = 3'd0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: out_valid=%b in_ready=%h required out_valid=0 in_ready=00", out_valid, in_ready);
        end
        checks++;
        if (out_data !== 8'h00 || out_ch !== 3'd0) begin
            errors++;
            $display("FAIL reset_values: out_data=%h out_ch=%0d required 00/0", out_data, out_ch);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 8'h01) begin
            errors++;
            $display("FAIL reset_first_ready: in_ready=%h required 01", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== in_data[7:0]) begin
            errors++;
            $display("FAIL reset_first_ch: valid=%b ch=%0d data=%h required 1/0/%h", out_valid, out_ch, out_data, in_data[7:0]);
        end
    endtask

    task automatic test_fixed();
        logic [7:0] exp_r;
        mode = 1'b0;
        sel = 3'd3;
        in_data = {$urandom, $urandom};
        in_data[3*W +: W] = 8'hA5;
        in_valid = 8'b0000_1000 | 8'($urandom);
        out_ready = 1'b1;
        #1;
        exp_r = model_ready();
        checks++;
        if (in_ready !== 8'b0000_1000 || in_ready !== exp_r) begin
            errors++;
            $display("FAIL fixed_ready: in_ready=%b required %b", in_ready, 8'b0000_1000);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 3'd3) begin
            errors++;
            $display("FAIL fixed_out: valid=%b data=%h ch=%0d required 1/a5/3", out_valid, out_data, out_ch);
        end
        // Selected channel not valid: no grant, register drains.
        in_valid = 8'b1111_0111;
        #1;
        checks++;
        if (in_ready !== 8'h00) begin
            errors++;
            $display("FAIL fixed_novalid_ready: in_ready=%b required 00000000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_ch !== 3'd3) begin
            errors++;
            $display("FAIL fixed_drain: valid=%b data=%h ch=%0d required 0/a5/3", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_rr_wrap();
        do_reset();
        mode = 1'b1;
        in_valid = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = {$urandom, $urandom};
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                errors++;
                $display("FAIL rr_wrap_ready[%0d]: in_ready=%b required %b", i, in_ready, model_ready());
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 3'(i % N) || out_data !== m_data) begin
                errors++;
                $display("FAIL rr_wrap_out[%0d]: valid=%b ch=%0d data=%h required 1/%0d/%h", i, out_valid, out_ch, out_data, i % N, m_data);
            end
        end
    endtask

    task automatic test_skip_idle();
        int exp_seq[4] = '{6, 2, 6, 2};
        do_reset();
        mode = 1'b1;
        out_ready = 1'b1;
        in_valid = 8'b0000_0100;
        in_data = {$urandom, $urandom};
        tick();
        in_valid = 8'b0100_0100;
        for (int i = 0; i < 4; i++) begin
            in_data = {$urandom, $urandom};
            #1;
            checks++;
            if ((in_ready & 8'b1011_1011) !== 8'h00 || in_ready !== 8'(1 << exp_seq[i])) begin
                errors++;
                $display("FAIL skip_ready[%0d]: in_ready=%b required %b", i, in_ready, 8'(1 << exp_seq[i]));
            end
            tick();
            checks++;
            if (out_ch !== 3'(exp_seq[i]) || out_data !== m_data || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL skip_out[%0d]: ch=%0d data=%h required %0d/%h", i, out_ch, out_data, exp_seq[i], m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] hold_d;
        logic [2:0] hold_c;
        mode = 1'b1;
        in_valid = 8'hFF;
        out_ready = 1'b1;
        in_data = {$urandom, $urandom};
        tick();
        hold_d = out_data;
        hold_c = out_ch;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = {$urandom, $urandom};
            in_valid = 8'($urandom) | 8'h01;
            mode = 1'($urandom);
            sel = 3'($urandom);
            #1;
            checks++;
            if (in_ready !== 8'h00) begin
                errors++;
                $display("FAIL stall_ready[%0d]: in_ready=%b required 00000000", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== hold_d || out_ch !== hold_c) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h ch=%0d required 1/%h/%0d", i, out_valid, out_data, out_ch, hold_d, hold_c);
            end
        end
        mode = 1'b1;
        in_valid = 8'hFF;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready === 8'h00 || in_ready !== model_ready()) begin
            errors++;
            $display("FAIL stall_release_ready: in_ready=%b required %b", in_ready, model_ready());
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 3'(m_ch) || out_data !== m_data) begin
            errors++;
            $display("FAIL stall_refill: ch=%0d data=%h required %0d/%h", out_ch, out_data, m_ch, m_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_data = {$urandom, $urandom};
            in_valid = 8'($urandom) & 8'($urandom);
            mode = 1'($urandom_range(0, 3) != 0);
            sel = 3'($urandom);
            out_ready = 1'($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                errors++;
                $display("FAIL rand_ready[%0d]: in_ready=%b required %b", i, in_ready, model_ready());
            end
            tick();
            checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_ch !== 3'(m_ch)) begin
                errors++;
                $display("FAIL rand_out[%0d]: valid=%b data=%h ch=%0d required %b/%h/%0d", i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
            end
        end
    endtask

    task automatic test_async_reset();
        mode = 1'b1;
        in_valid = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 3 + $urandom_range(0, 4); i++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: out_valid=%b required 1", out_valid);
        end
        #($urandom_range(0, 6));
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 8'h00) begin
            errors++;
            $display("FAIL async_drop: out_valid=%b in_ready=%h required 0/00", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 8'h00) begin
            errors++;
            $display("FAIL async_held: out_valid=%b in_ready=%h required 0/00", out_valid, in_ready);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = {$urandom, $urandom};
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 3'(i) || out_data !== m_data) begin
                errors++;
                $display("FAIL async_restart[%0d]: ch=%0d data=%h required %0d/%h", i, out_ch, out_data, i, m_data);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        in_data = '0;
        in_valid = '0;
        mode = 1'b0;
        sel = 3'd0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_fixed();
        test_rr_wrap();
        test_skip_idle();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
